// File: rtl/ddr3_dev_responder.sv
// DDR3 device-side responder: decodes the command bus, tracks per-bank row state and
// activate/precharge ages, stores BL8 write bursts, returns reads at CAS latency, flags the first violation.
module ddr3_dev_responder #(
    parameter int DQ_BITS   = 8,
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 14,
    parameter int T_RCD     = 6,
    parameter int T_CL      = 6,
    parameter int T_WL      = 8,
    parameter int T_RAS     = 15,
    parameter int T_RP      = 6,
    parameter int T_MRD     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cs_n,
    input  logic                   i_ras_n,
    input  logic                   i_cas_n,
    input  logic                   i_we_n,
    input  logic [BA_BITS-1:0]     i_ba,
    input  logic [ADDR_BITS-1:0]   i_addr,
    input  logic [2*DQ_BITS-1:0]   i_wdata,
    output logic [2*DQ_BITS-1:0]   o_rdata,
    output logic                   o_rvalid,
    output logic                   o_ready,
    output logic                   o_err,
    output logic [2:0]             o_err_code
);
    localparam int NB = 1 << BA_BITS;
    localparam int W  = 2 * DQ_BITS;
    localparam logic [4:0] RCD    = 5'(T_RCD);
    localparam logic [4:0] RAS    = 5'(T_RAS);
    localparam logic [4:0] RP     = 5'(T_RP);
    localparam logic [4:0] MRD_LD = 5'(T_MRD - 1);
    localparam logic [4:0] RD_LEN = 5'(T_CL + 3);
    localparam logic [4:0] WR_LEN = 5'(T_WL + 3);

    typedef enum logic {S_INIT, S_READY} state_t;
    state_t r_state, w_state_nxt;

    logic [NB-1:0]                r_open;
    logic [NB-1:0][ADDR_BITS-1:0] r_row;
    logic [NB-1:0][4:0]           r_act_age, r_pre_age;
    logic [4:0]                   r_mrd_cnt, r_bcnt;
    logic                         r_armed, r_is_rd, r_err, r_rvalid;
    logic [2:0]                   r_err_code;
    logic [5:0]                   r_widx;
    logic [3:0][W-1:0]            r_rbuf, r_wbuf;
    logic [W-1:0]                 r_rdata;
    logic [3:0][W-1:0]            r_mem [0:63];

    logic [2:0]    w_rcw, w_code;
    logic          w_nop, w_act, w_rd, w_wr, w_pre, w_mrs, w_ref;
    logic [NB-1:0] w_ras_blk;
    logic [5:0]    w_idx;
    logic          w_beat_act;
    logic [1:0]    w_beat;

    assign w_rcw = {i_ras_n, i_cas_n, i_we_n};
    assign w_nop = i_cs_n || (w_rcw == 3'b111) || (w_rcw == 3'b110);
    assign w_act = !i_cs_n && (w_rcw == 3'b011);
    assign w_rd  = !i_cs_n && (w_rcw == 3'b101);
    assign w_wr  = !i_cs_n && (w_rcw == 3'b100);
    assign w_pre = !i_cs_n && (w_rcw == 3'b010);
    assign w_mrs = !i_cs_n && (w_rcw == 3'b000);
    assign w_ref = !i_cs_n && (w_rcw == 3'b001);
    assign w_idx = {i_ba[1:0], r_row[i_ba][1:0], i_addr[4:3]};
    // The burst counter doubles as the data-beat sequencer over its last four counts.
    assign w_beat_act = (r_bcnt != 5'd0) && (r_bcnt <= 5'd4);
    assign w_beat     = 2'(3'd4 - r_bcnt[2:0]);

    always_comb begin
        w_ras_blk = '0;
        for (int b = 0; b < NB; b++)
            w_ras_blk[b] = r_open[b] && (r_act_age[b] < RAS);
        w_code = 3'd0;
        if (!w_nop) begin
            if (r_mrd_cnt != 5'd0)                         w_code = 3'd7;
            else if (!r_armed && !w_mrs)                   w_code = 3'd1;
            else if (w_rd || w_wr) begin
                if (!r_open[i_ba])                         w_code = 3'd2;
                else if (r_act_age[i_ba] < RCD)            w_code = 3'd3;
                else if (r_bcnt != 5'd0)                   w_code = 3'd7;
            end else if (w_act) begin
                if (r_open[i_ba])                          w_code = 3'd4;
                else if (r_pre_age[i_ba] < RP)             w_code = 3'd5;
            end else if (w_pre) begin
                if (i_addr[10] ? (|w_ras_blk) : w_ras_blk[i_ba]) w_code = 3'd6;
            end else if (w_ref && (|r_open))               w_code = 3'd4;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && r_armed && r_mrd_cnt == 5'd0)
            w_state_nxt = S_READY;
        o_ready = (r_state == S_READY);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_INIT;
            r_open     <= '0;
            r_row      <= '0;
            r_act_age  <= '1;
            r_pre_age  <= '1;
            r_mrd_cnt  <= '0;
            r_bcnt     <= '0;
            r_armed    <= 1'b0;
            r_is_rd    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_widx     <= '0;
            r_rbuf     <= '0;
            r_wbuf     <= '0;
        end else begin
            r_state <= w_state_nxt;
            for (int b = 0; b < NB; b++) begin
                if (r_act_age[b] != 5'd31) r_act_age[b] <= r_act_age[b] + 5'd1;
                if (r_pre_age[b] != 5'd31) r_pre_age[b] <= r_pre_age[b] + 5'd1;
            end
            if (r_mrd_cnt != 5'd0) r_mrd_cnt <= r_mrd_cnt - 5'd1;
            if (r_bcnt != 5'd0)    r_bcnt    <= r_bcnt - 5'd1;
            r_rvalid <= r_is_rd && w_beat_act;
            r_rdata  <= (r_is_rd && w_beat_act) ? r_rbuf[w_beat] : '0;
            if (!r_is_rd && w_beat_act) r_wbuf[w_beat] <= i_wdata;
            if (w_code != 3'd0) begin
                if (!r_err) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_code;
                end
            end else if (!w_nop) begin
                if (w_mrs) begin
                    r_mrd_cnt <= MRD_LD;
                    r_armed   <= 1'b1;
                end
                if (w_act) begin
                    r_open[i_ba]    <= 1'b1;
                    r_row[i_ba]     <= i_addr;
                    r_act_age[i_ba] <= 5'd1;
                end
                if (w_pre) begin
                    for (int b = 0; b < NB; b++)
                        if ((i_addr[10] || BA_BITS'(b) == i_ba) && r_open[b]) begin
                            r_open[b]    <= 1'b0;
                            r_pre_age[b] <= 5'd1;
                        end
                end
                if (w_rd) begin
                    r_bcnt  <= RD_LEN;
                    r_is_rd <= 1'b1;
                    r_rbuf  <= r_mem[w_idx];
                end
                if (w_wr) begin
                    r_bcnt  <= WR_LEN;
                    r_is_rd <= 1'b0;
                    r_widx  <= w_idx;
                end
            end
        end
    end

    // Burst storage is deliberately left unreset; a reset clears r_bcnt so no commit follows.
    always_ff @(posedge i_clk) begin
        if (!r_is_rd && r_bcnt == 5'd1)
            r_mem[r_widx] <= {i_wdata, r_wbuf[2], r_wbuf[1], r_wbuf[0]};
    end

    assign o_rdata    = r_rdata;
    assign o_rvalid   = r_rvalid;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
endmodule
